// File: rtl/counter_ctrl_pkg.sv
// Shared types and defaults for the counter sequencing controller.
package counter_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } ctrl_state_t;

   localparam int N_DEF = 8;
   localparam int P_DEF = 8;

endpackage

// File: rtl/counter_ctrl.sv
// Sequencer for an external enable/reset counter: one-shot or auto-reload intervals.
// Optional period counter enabled by defining COUNTER_CTRL_PERIOD_CNT_EN.
module counter_ctrl
   import counter_ctrl_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int P = P_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         stop,
   input  logic         hold,
   input  logic         auto_reload,
   input  logic [N-1:0] limit,
   input  logic [N-1:0] cnt_q,
   output logic         cnt_en,
   output logic         cnt_rst,
   output logic         busy,
   output logic         done,
   output logic [P-1:0] period_cnt
);

   ctrl_state_t  state;
   logic [N-1:0] limit_r;
   logic         auto_r;
   logic         adv;
   logic         tc;
   logic         go;
   logic         wrap;

   // limit_r of 0 wraps to all-ones, giving a 2^N period
   assign tc      = (cnt_q == limit_r - N'(1));
   assign adv     = (state == RUN) && !hold;
   assign go      = start && !stop && (state != RUN);
   assign wrap    = adv && tc && auto_r;
   assign cnt_en  = adv && !rst;
   assign cnt_rst = rst || stop || (state == IDLE) || wrap ||
                    ((state == DONE) && start);
   assign busy    = (state == RUN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         limit_r <= '0;
         auto_r  <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= adv && tc && !stop;
         if (stop) begin
            state <= IDLE;
         end else if (go) begin
            state   <= RUN;
            limit_r <= limit;
            auto_r  <= auto_reload;
         end else if (adv && tc && !auto_r) begin
            state <= DONE;
         end
      end
   end

`ifdef COUNTER_CTRL_PERIOD_CNT_EN
   logic [P-1:0] period_r;

   always_ff @(posedge clk) begin
      if (rst || go) begin
         period_r <= '0;
      end else if (wrap && !stop && (period_r != '1)) begin
         period_r <= period_r + P'(1);
      end
   end

   assign period_cnt = period_r;
`else
   assign period_cnt = '0;
`endif

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl with the enable/reset counter modelled alongside.
module tb_counter_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       stop;
   logic       hold;
   logic       auto_reload;
   logic [7:0] limit;
   logic [7:0] q;
   logic       cnt_en;
   logic       cnt_rst;
   logic       busy;
   logic       done;
   logic [7:0] period_cnt;

   int total = 0;
   int bad   = 0;
   int errs;

   counter_ctrl #(.N(8), .P(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .stop        (stop),
      .hold        (hold),
      .auto_reload (auto_reload),
      .limit       (limit),
      .cnt_q       (q),
      .cnt_en      (cnt_en),
      .cnt_rst     (cnt_rst),
      .busy        (busy),
      .done        (done),
      .period_cnt  (period_cnt)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      if (cnt_rst)     q <= '0;
      else if (cnt_en) q <= q + 8'd1;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic kick(input logic [7:0] lim, input logic ar);
      limit       = lim;
      auto_reload = ar;
      start       = 1'b1;
      step();
      start       = 1'b0;
   endtask

   logic [7:0] per_exp;

   initial begin
`ifdef COUNTER_CTRL_PERIOD_CNT_EN
      per_exp = 8'd4;
`else
      per_exp = 8'd0;
`endif
      rst = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0;
      auto_reload = 1'b0; limit = 8'd0;

      // reset
      step(); step();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_per", period_cnt, 0);
      chk("rst_crst", cnt_rst, 1);
      chk("rst_cen", cnt_en, 0);
      chk("rst_q", q, 0);
      rst = 1'b0;
      step();

      // one-shot, limit 5
      kick(8'd5, 1'b0);
      chk("os_q0", q, 0);
      chk("os_busy0", busy, 1);
      errs = 0;
      for (int i = 1; i <= 4; i++) begin
         step();
         if (q != 8'(i) || !busy || done) errs++;
      end
      chk("os_run", errs, 0);
      step();
      chk("os_q5", q, 5);
      chk("os_done", done, 1);
      chk("os_busy", busy, 0);
      errs = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (q != 8'd5 || done || busy) errs++;
      end
      chk("os_hold5", errs, 0);

      // auto-reload, limit 3, with an ignored start mid-run
      kick(8'd3, 1'b1);
      chk("ar_q0", q, 0);
      chk("ar_per0", period_cnt, 0);
      errs = 0;
      for (int i = 1; i <= 12; i++) begin
         start = (i == 5);
         limit = (i == 5) ? 8'd7 : 8'd3;
         step();
         if (q != 8'(i % 3)) errs++;
         if (done != (i % 3 == 0)) errs++;
         if (!busy) errs++;
      end
      start = 1'b0;
      chk("ar_seq", errs, 0);
      chk("ar_per", period_cnt, per_exp);
      chk("ar_busy", busy, 1);

      // stop out of auto-reload keeps period_cnt
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("ar_stop_q", q, 0);
      chk("ar_stop_busy", busy, 0);
      chk("ar_stop_per", period_cnt, per_exp);

      // hold at q=2 for 3 cycles and at tc for 2 cycles
      kick(8'd5, 1'b0);
      chk("hd_per_clr", period_cnt, 0);
      step(); step();
      chk("hd_q2", q, 2);
      hold = 1'b1;
      errs = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (q != 8'd2 || !busy || done) errs++;
      end
      chk("hd_frz", errs, 0);
      hold = 1'b0;
      step(); step();
      chk("hd_q4", q, 4);
      hold = 1'b1;
      errs = 0;
      for (int i = 0; i < 2; i++) begin
         step();
         if (q != 8'd4 || !busy || done) errs++;
      end
      chk("hd_tc_frz", errs, 0);
      hold = 1'b0;
      step();
      chk("hd_q5", q, 5);
      chk("hd_done", done, 1);
      chk("hd_busy", busy, 0);

      // stop at q=3 with a simultaneous start
      kick(8'd5, 1'b0);
      step(); step(); step();
      chk("sp_q3", q, 3);
      stop = 1'b1;
      start = 1'b1;
      step();
      stop = 1'b0;
      start = 1'b0;
      chk("sp_q", q, 0);
      chk("sp_busy", busy, 0);
      chk("sp_done", done, 0);
      chk("sp_crst", cnt_rst, 1);
      step();
      chk("sp_idle", busy, 0);

      // limit 0 means 256 cycles
      kick(8'd0, 1'b0);
      errs = 0;
      for (int i = 1; i <= 255; i++) begin
         step();
         if (q != 8'(i) || done || !busy) errs++;
      end
      chk("l0_run", errs, 0);
      step();
      chk("l0_q", q, 0);
      chk("l0_done", done, 1);
      chk("l0_busy", busy, 0);
      step();
      chk("l0_q_hold", q, 0);
      chk("l0_done_clr", done, 0);

      // limit 1
      kick(8'd1, 1'b0);
      chk("l1_q0", q, 0);
      chk("l1_busy", busy, 1);
      step();
      chk("l1_q1", q, 1);
      chk("l1_done", done, 1);
      chk("l1_idle", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
